// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types for the shift_register datapath and its
//                upstream shift_serializer driver: the command encoding on
//                the funct/serial interface, the shift direction, and the
//                serializer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

    // Command presented to a shift_register on each cycle.
    typedef enum logic [1:0] {
        NA    = 2'b00,
        LOAD  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } funct_t;

    // Serialization order: LEFT sends MSB first, RIGHT sends LSB first.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } ser_state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_serializer
//  Description : Parallel-to-serial writer for a downstream shift_register of
//                the same WIDTH. A word accepted over valid/ready is replayed
//                as WIDTH LEFT (MSB first) or RIGHT (LSB first) commands with
//                the matching serial bit, so the downstream register holds
//                exactly the accepted word after the last command.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous active-high reset
//                valid_i  - upstream word valid
//                ready_o  - word can be accepted this cycle (IDLE)
//                word_i   - parallel word, sampled on handshake
//                dir_i    - 0: MSB first with LEFT, 1: LSB first with RIGHT
//                funct_o  - command to the downstream shift_register
//                serial_o - serial bit to the downstream shift_register
//                busy_o   - transfer in progress (SHIFT or DONE)
//                done_o   - one-cycle pulse after the final shift command
//  Revision    : 1.0  initial release
// ============================================================================
module shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] word_i,
    input  logic             dir_i,
    output funct_t           funct_o,
    output logic             serial_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ser_state_t       state_q,  state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    dir_t             dir_q,    dir_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // ------------------------------------------------------------------
    // Next-state logic. The shadow register is a frozen copy of the
    // accepted word; it shifts toward the exposed end each SHIFT cycle so
    // the outgoing bit is always at a fixed position.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                // ready_o is high throughout IDLE, so valid_i alone is the handshake.
                if (valid_i) begin
                    shadow_d = word_i;
                    dir_d    = dir_t'(dir_i);
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (dir_q == DIR_LEFT) begin
                    shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
                end else begin
                    shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
                end
                // Counter parks on its last value; the next accept clears it.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            dir_q    <= DIR_LEFT;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state only; no input reaches an output.
    // ------------------------------------------------------------------
    always_comb begin
        ready_o  = (state_q == IDLE);
        busy_o   = (state_q == SHIFT) || (state_q == DONE);
        done_o   = (state_q == DONE);
        funct_o  = NA;
        serial_o = 1'b0;
        if (state_q == SHIFT) begin
            if (dir_q == DIR_LEFT) begin
                funct_o  = LEFT;
                serial_o = shadow_q[WIDTH-1];
            end else begin
                funct_o  = RIGHT;
                serial_o = shadow_q[0];
            end
        end
    end

endmodule : shift_serializer
`default_nettype wire

// File: tb/tb_shift_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_serializer
//  Description : Self-checking bench for shift_serializer. A WIDTH=4 and a
//                WIDTH=8 instance each drive a behavioural shift_register
//                sink; expected commands are queued when a word is offered
//                and popped as the serializer emits them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_serializer;
    import shift_pkg::*;

    typedef struct packed {
        funct_t f;
        logic   s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       valid4 = 1'b0;
    logic       ready4;
    logic [3:0] word4  = '0;
    logic       dir4   = 1'b0;
    funct_t     funct4;
    logic       serial4, busy4, done4;

    logic       valid8 = 1'b0;
    logic       ready8;
    logic [7:0] word8  = '0;
    logic       dir8   = 1'b0;
    funct_t     funct8;
    logic       serial8, busy8, done8;

    logic [3:0] sink4;
    logic [7:0] sink8;
    int         load_seen = 0;
    int         done_cnt4 = 0;

    int         n_tests = 0;
    int         n_fail  = 0;

    exp_t       exp_q[$];
    logic [3:0] word_q[$];

    always #5 clk = ~clk;

    shift_serializer #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .valid_i(valid4), .ready_o(ready4),
        .word_i(word4), .dir_i(dir4), .funct_o(funct4), .serial_o(serial4),
        .busy_o(busy4), .done_o(done4)
    );

    shift_serializer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .valid_i(valid8), .ready_o(ready8),
        .word_i(word8), .dir_i(dir8), .funct_o(funct8), .serial_o(serial8),
        .busy_o(busy8), .done_o(done8)
    );

    // Downstream shift_register behaviour: LEFT {q[W-2:0],s}, RIGHT {s,q[W-1:1]}.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sink4 <= '0;
        end else begin
            case (funct4)
                LEFT:    sink4 <= {sink4[2:0], serial4};
                RIGHT:   sink4 <= {serial4, sink4[3:1]};
                LOAD:    load_seen <= load_seen + 1;
                default: sink4 <= sink4;
            endcase
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sink8 <= '0;
        end else begin
            case (funct8)
                LEFT:    sink8 <= {sink8[6:0], serial8};
                RIGHT:   sink8 <= {serial8, sink8[7:1]};
                LOAD:    load_seen <= load_seen + 1;
                default: sink8 <= sink8;
            endcase
        end
    end

    always @(negedge clk) begin
        if (done4 === 1'b1) done_cnt4 <= done_cnt4 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the command stream a correct serializer must produce for w/d.
    task automatic push_expect(input logic [3:0] w, input logic d);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.f = d ? RIGHT : LEFT;
            e.s = d ? w[i] : w[3-i];
            exp_q.push_back(e);
        end
        word_q.push_back(w);
    endtask

    // Called #1 into the first SHIFT cycle; returns #1 into the following IDLE.
    task automatic run_shift4(input bit toggle);
        exp_t       e;
        logic [3:0] w;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            chk("shift_funct",  funct4,  e.f);
            chk("shift_serial", serial4, e.s);
            chk("shift_busy",   busy4,   1);
            chk("shift_ready",  ready4,  0);
            chk("shift_done",   done4,   0);
            if (toggle) begin
                valid4 = ~valid4;
                word4  = ~word4;
                dir4   = ~dir4;
            end
            tick();
        end
        w = word_q.pop_front();
        chk("done_pulse", done4,  1);
        chk("done_funct", funct4, NA);
        chk("done_ready", ready4, 0);
        chk("done_busy",  busy4,  1);
        chk("sink_word",  sink4,  w);
        tick();
        chk("idle_ready", ready4, 1);
        chk("idle_done",  done4,  0);
        chk("idle_funct", funct4, NA);
    endtask

    task automatic send4(input logic [3:0] w, input logic d);
        valid4 = 1'b1;
        word4  = w;
        dir4   = d;
        chk("accept_ready", ready4, 1);
        push_expect(w, d);
        tick();
        valid4 = 1'b0;
        run_shift4(1'b0);
    endtask

    initial begin
        int         base;
        logic [7:0] w8;

        // Reset state, visible while rst is still asserted.
        #2;
        chk("rst_ready",  ready4,  1);
        chk("rst_funct",  funct4,  NA);
        chk("rst_serial", serial4, 0);
        chk("rst_busy",   busy4,   0);
        chk("rst_done",   done4,   0);
        chk("rst_ready8", ready8,  1);
        tick();
        rst = 1'b0;
        tick();

        // 1: MSB first with LEFT.
        send4(4'b1011, 1'b0);
        // 2: LSB first with RIGHT.
        send4(4'b1011, 1'b1);

        // 3: valid held high; second word must wait for IDLE.
        valid4 = 1'b1;
        word4  = 4'hA;
        dir4   = 1'b0;
        push_expect(4'hA, 1'b0);
        tick();
        word4 = 4'h5;
        run_shift4(1'b0);
        chk("held_sink_a", sink4, 4'hA);
        push_expect(4'h5, 1'b0);
        tick();
        valid4 = 1'b0;
        run_shift4(1'b0);

        // 4: reset in the middle of a transfer.
        base   = done_cnt4;
        valid4 = 1'b1;
        word4  = 4'hF;
        dir4   = 1'b0;
        tick();
        valid4 = 1'b0;
        chk("pre_rst_funct", funct4, LEFT);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_funct", funct4, NA);
        chk("rst_mid_ready", ready4, 1);
        chk("rst_mid_busy",  busy4,  0);
        chk("rst_mid_done",  done4,  0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_no_done", done_cnt4 - base, 0);
        send4(4'h3, 1'b0);

        // 5: inputs toggling during SHIFT must not disturb the transfer.
        base   = done_cnt4;
        valid4 = 1'b1;
        word4  = 4'h6;
        dir4   = 1'b1;
        push_expect(4'h6, 1'b1);
        tick();
        run_shift4(1'b1);
        valid4 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("toggle_one_done", done_cnt4 - base, 1);

        // 6: WIDTH=8, LSB first.
        w8     = 8'hC3;
        valid8 = 1'b1;
        word8  = w8;
        dir8   = 1'b1;
        tick();
        valid8 = 1'b0;
        word8  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("w8_funct",  funct8,  RIGHT);
            chk("w8_serial", serial8, w8[i]);
            chk("w8_done",   done8,   0);
            tick();
        end
        chk("w8_done_pulse", done8,  1);
        chk("w8_done_funct", funct8, NA);
        chk("w8_sink",       sink8,  8'hC3);
        tick();
        chk("w8_idle_ready", ready8, 1);

        chk("no_load", load_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_serializer
`default_nettype wire

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
Parallel-to-serial driver that feeds the team's shift_register. It accepts a parallel word over a valid/ready handshake and emits WIDTH consecutive LEFT or RIGHT commands with matching serial bits. After the last command, a downstream shift_register of the same WIDTH holds exactly the accepted word. It sits upstream of shift_register as the writer side of its funct/serial interface.

Parameters:
WIDTH, 4, word width; must be >= 2; must equal the downstream shift_register WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset, asynchronous, active-high.
valid_i  input  1  upstream word valid.
ready_o  output  1  serializer can accept a word this cycle.
word_i  input  WIDTH  parallel word, sampled on handshake.
dir_i  input  1  0 = MSB-first using LEFT; 1 = LSB-first using RIGHT; sampled on handshake.
funct_o  output  funct_t (2)  command to the downstream shift_register.
serial_o  output  1  serial bit to the downstream shift_register.
busy_o  output  1  a transfer is in progress (SHIFT or DONE).
done_o  output  1  one-cycle pulse after the final shift command.

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE, shadow = 0, dir_q = 0, cnt = 0.
  - Outputs: ready_o = 1, funct_o = NA, serial_o = 0, busy_o = 0, done_o = 0.
- Outputs decode combinationally from registered state, shadow and dir_q only. No combinational path from any input to any output.
- Handshake: transfer occurs when valid_i && ready_o at posedge. ready_o = (state == IDLE).
- IDLE:
  - funct_o = NA, serial_o = 0.
  - On handshake: shadow <= word_i, dir_q <= dir_i, cnt <= 0, state <= SHIFT.
- SHIFT (exactly WIDTH cycles):
  - funct_o = LEFT if dir_q == 0, else RIGHT.
  - serial_o = shadow[WIDTH-1] for LEFT, shadow[0] for RIGHT.
  - Each cycle the shadow shifts internally to expose the next bit: left for LEFT, right for RIGHT, zero-filled. cnt increments.
  - When cnt == WIDTH-1: state <= DONE.
- DONE (1 cycle): funct_o = NA, done_o = 1, ready_o = 0; state <= IDLE.
- Timing:
  - Latency: handshake edge -> first shift command visible in the following cycle.
  - The last command occupies the WIDTH-th SHIFT cycle; done_o is asserted the cycle after.
  - Throughput: one word per WIDTH+2 cycles (IDLE accept cycle + WIDTH shifts + DONE).
- Correctness: with downstream shift_register semantics (LEFT: {q[W-2:0], s}; RIGHT: {s, q[W-1:1]}), both directions leave q == captured word after the final shift.
- cnt width: $clog2(WIDTH); no wrap beyond WIDTH-1.
- Boundaries:
  - valid_i while busy: ignored (ready_o = 0); no capture, no corruption.
  - word_i/dir_i changes during SHIFT: no effect; shadow and dir_q are frozen copies.
  - valid_i held high continuously: next word accepted in the IDLE cycle after DONE; IDLE lasts exactly one cycle.
  - rst mid-SHIFT: immediately returns to IDLE, funct_o = NA. The downstream register is expected to be reset by the same rst; no partial-transfer recovery.
  - LOAD is never emitted by this block.

Decomposition:
- Shared package shift_pkg:
  - funct_t enum (NA = 00, LOAD = 01, LEFT = 10, RIGHT = 11), moved out of shift_register and imported by both blocks.
  - dir_t enum (DIR_LEFT = 0, DIR_RIGHT = 1).
  - State enum ser_state_t {IDLE, SHIFT, DONE}.
- No sub-module needed: single FSM plus counter plus shadow register.
- Bench instantiates shift_register downstream as the checking sink.

Test Plan:
1. WIDTH=4, word_i=4'b1011, dir_i=0, one handshake -> four LEFT cycles with serial_o 1,0,1,1; done_o pulses next cycle; downstream out_o == 4'b1011.
2. WIDTH=4, word_i=4'b1011, dir_i=1 -> four RIGHT cycles with serial_o 1,1,0,1; downstream out_o == 4'b1011; funct_o == NA in DONE.
3. valid_i held high with words 4'hA then 4'h5 -> ready_o low for 5 cycles between accepts; second word presented to word_i during the first transfer is not captured until IDLE; downstream shows 4'hA then 4'h5.
4. Accept 4'hF (dir 0), assert rst after 2 SHIFT cycles -> same-cycle funct_o = NA, ready_o = 1, busy_o = 0, done_o never pulses; next word 4'h3 transfers correctly.
5. During SHIFT, toggle valid_i, word_i and dir_i every cycle -> serial stream and direction unchanged from the captured values; exactly one done_o pulse.
6. WIDTH=8, word_i=8'hC3, dir_i=1 -> eight RIGHT cycles with serial_o 1,1,0,0,0,0,1,1; downstream out_o == 8'hC3; done_o at cycle 9 after the handshake.
